uart_receiver: RTL

- Serial-to-parallel UART receiver with 16x oversampling. Pairs with the team's UART transmitter and shares the baud-rate generator's i_bd_tick.
- Synchronises the asynchronous rx line and validates the start bit at mid-bit. Samples each data bit LSB-first and checks the stop bit.
- Presents each received byte with a single-cycle done strobe and a framing-error flag. Feeds the downstream FIFO/interface logic.

---
 rtl/uart_receiver_if.sv | 36 +++
 rtl/uart_receiver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if
//   Groups the serial-side and parallel-side signals of the UART receiver.
//   The receiver connects through the slave modport. Whatever drives the line
//   and the baud tick, and consumes the received words, uses the master modport.
//   Signals:
//     i_rx        serial line, idle high
//     i_bd_tick   one-cycle oversampling tick, 16 per bit
//     o_data      last received word
//     o_rx_done   one-cycle strobe when o_data/o_frame_err update
//     o_frame_err stop-bit sample of the last frame was 0
`timescale 1ns/1ps
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx;
  logic                 i_bd_tick;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_rx_done;
  logic                 o_frame_err;

  modport master (
    output i_rx,
    output i_bd_tick,
    input  o_data,
    input  o_rx_done,
    input  o_frame_err
  );

  modport slave (
    input  i_rx,
    input  i_bd_tick,
    output o_data,
    output o_rx_done,
    output o_frame_err
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver
//   UART receiver with 16x oversampling. The rx line is double-flop
//   synchronised. A start bit is confirmed at its centre (tick 7). Each data
//   bit is then sampled 16 ticks later, LSB first, and the stop bit is
//   sampled after STP_BITS_TICKS ticks. Each frame produces a one-cycle
//   done strobe together with the received word and a framing-error flag.
//   Ports:
//     i_clk    system clock (rising edge)
//     i_reset  asynchronous active-high reset
//     rx_if    uart_receiver_if.slave: i_rx, i_bd_tick in; o_data,
//              o_rx_done, o_frame_err out
//   Parameters:
//     DATA_BITS       5..8 data bits per frame
//     STP_BITS_TICKS  16 / 24 / 32 ticks of stop bit
`timescale 1ns/1ps
module uart_receiver #(
  parameter int DATA_BITS      = 8,
  parameter int STP_BITS_TICKS = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  uart_receiver_if.slave  rx_if
);

  // The tick counter must reach both the 15-tick data period and the stop length.
  localparam int TICK_MAX = (STP_BITS_TICKS - 1 > 15) ? (STP_BITS_TICKS - 1) : 15;
  localparam int TW       = $clog2(TICK_MAX + 1);
  localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_MID_START = TW'(7);
  localparam logic [TW-1:0] TICK_BIT_END   = TW'(15);
  localparam logic [TW-1:0] TICK_STOP_END  = TW'(STP_BITS_TICKS - 1);
  localparam logic [BW-1:0] LAST_BIT       = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_STOP       = 3'd3,
    S_BREAK_WAIT = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [TW-1:0]        tick_reg, tick_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 err_reg, err_next;
  logic                 done_reg, done_next;
  logic [1:0]           sync_reg;
  logic                 rx_s;

  // Two-flop synchroniser. It resets to 1 so that the line reads idle out of reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx_if.i_rx};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= S_IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    err_next   = err_reg;
    done_next  = 1'b0;

    case (state_reg)
      // The start edge is taken on any cycle, not only on a tick, so that
      // the following ticks are counted from the edge.
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          tick_next  = '0;
        end
      end

      S_START: begin
        if (rx_if.i_bd_tick) begin
          if (tick_reg == TICK_MID_START) begin
            if (!rx_s) begin
              state_next = S_DATA;
              tick_next  = '0;
              bit_next   = '0;
            end else begin
              // The line went back high before mid-bit: treat it as a glitch.
              state_next = S_IDLE;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (rx_if.i_bd_tick) begin
          if (tick_reg == TICK_BIT_END) begin
            tick_next  = '0;
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_reg == LAST_BIT) begin
              state_next = S_STOP;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (rx_if.i_bd_tick) begin
          if (tick_reg == TICK_STOP_END) begin
            data_next  = shift_reg;
            err_next   = ~rx_s;
            done_next  = 1'b1;
            // A low stop bit means the line may be held in break. Wait for it
            // to return high so that the break does not produce repeated frames.
            state_next = rx_s ? S_IDLE : S_BREAK_WAIT;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      S_BREAK_WAIT: begin
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign rx_if.o_data      = data_reg;
  assign rx_if.o_rx_done   = done_reg;
  assign rx_if.o_frame_err = err_reg;

endmodule
